// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: scan controller for the 8-digit display path.
// Produces the 3-bit digit index and enable for the downstream 3-to-8
// select decoder. Each digit slot lasts DIV cycles. The enable is held
// low for the first BLANK cycles of every slot so the decoder never
// drives a digit while the index is settling (anti-ghosting).
module digit_scan_ctrl #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 4,
    parameter int unsigned LAST  = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clr,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic       tick,
    output logic       frame
);

    localparam int unsigned CW = $clog2(DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    // Terminal slot count, last blanking count and highest index.
    localparam logic [CW-1:0] CNT_TERM  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = (BLANK > 0) ? CW'(BLANK - 1) : '0;
    localparam logic [2:0]    SEL_LAST  = 3'(LAST);

    // State entered at the start of every slot; skips blanking when BLANK==0.
    localparam state_t SLOT_START = (BLANK == 0) ? ST_ON : ST_BLANK;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    sel_d;
    logic          tick_d;
    logic          frame_d;

    // State, slot counter, index and pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel     <= '0;
            tick    <= 1'b0;
            frame   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel     <= sel_d;
            tick    <= tick_d;
            frame   <= frame_d;
        end
    end

    // Next-state logic: clr beats run=0, which beats the slot advance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel;
        tick_d  = 1'b0;
        frame_d = 1'b0;

        if (clr) begin
            sel_d   = '0;
            cnt_d   = '0;
            state_d = run ? SLOT_START : ST_IDLE;
        end else if (!run) begin
            // Stopping never produces an advance, even on the terminal count.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = SLOT_START;
                end
                ST_BLANK, ST_ON: begin
                    if (cnt_q == CNT_TERM) begin
                        cnt_d   = '0;
                        sel_d   = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
                        tick_d  = 1'b1;
                        frame_d = (sel == SEL_LAST);
                        state_d = SLOT_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (state_q == ST_BLANK && cnt_q == BLANK_END) begin
                            state_d = ST_ON;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decoder enable is a pure decode of the registered state.
    always_comb begin
        sel_en = (state_q == ST_ON);
    end

endmodule
